tinycpu_trace: RTL and testbench
================================

TINYCPU_TRACE -- requirements
Module: tinycpu_trace

Interface
REQ-001 Parameter DEPTH, default 8, sets the trace FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter LOOP_OP, default 2'b11, is the instr[7:6] opcode checked for a forever loop.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset: 0 = reset asserted, 1 = run.
REQ-005 cpu_idle  input  1  CPU is in IDLE this cycle (instruction boundary).
REQ-006 cpu_exec  input  1  CPU is in EXEC this cycle.
REQ-007 cpu_op  input  2  CPU instr[7:6].
REQ-008 cpu_ra, cpu_rb, cpu_rm, cpu_rp  input  8 each  CPU registers A, B, M, P.
REQ-009 trace_ready  input  1  consumer accepts the head entry.
REQ-010 trace_valid  output  1  head entry is available.
REQ-011 trace_data  output  32  head entry, packed {A,B,M,P} with A in bits [31:24].
REQ-012 trace_level  output  5  current FIFO occupancy, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: at least one snapshot was dropped.
REQ-014 drop_cnt  output  8  dropped-snapshot count, saturating at 255.
REQ-015 halt  output  1  sticky flag: forever loop detected.
REQ-016 done  output  1  halt is set and the FIFO has drained empty.

Function
REQ-017 Snapshot push request = cpu_idle & ~halt; the pushed entry is {cpu_ra,cpu_rb,cpu_rm,cpu_rp} as sampled that cycle.
REQ-018 Loop detect = cpu_exec & (cpu_op == LOOP_OP) & (cpu_rp - 8'd1 == cpu_rm), computed mod 256, so rp=0x00 matches rm=0xFF.
REQ-019 A detect cycle sets halt on the next edge; any push in the detect cycle itself is still accepted.
REQ-020 cpu_idle and cpu_exec are evaluated independently; if both are high in one cycle, both push and detect apply.
REQ-021 Pop occurs when trace_valid & trace_ready; trace_data changes only on the edge after a pop or on the first push into an empty FIFO.
REQ-022 Latency: an entry pushed into an empty FIFO presents trace_valid=1 on the following cycle; there is no same-cycle bypass.
REQ-023 Push to a full FIFO without a simultaneous pop: drop the entry, set overflow, and increment drop_cnt (saturating at 255).
REQ-024 Simultaneous push and pop when full: accept both; level stays DEPTH and there is no drop.
REQ-025 Simultaneous push and pop when level is at least 1: accept both; level is unchanged and FIFO order is preserved.
REQ-026 Read and write pointers wrap modulo DEPTH; level is tracked separately so full and empty are never ambiguous.
REQ-027 Control FSM states:
  - RUN: halt=0, done=0.
  - DRAIN: halt=1, done=0.
  - DONE: halt=1, done=1.
REQ-028 RUN -> DRAIN on detect when the next-cycle level is greater than 0; RUN -> DONE on detect when the next-cycle level equals 0.
REQ-029 DRAIN -> DONE on the edge where a pop makes level 0.
REQ-030 DONE is terminal until reset; pops continue to be honoured in DRAIN and DONE.
REQ-031 Further detects in DRAIN or DONE have no effect.
REQ-032 Outputs are registered or derived only from registered state; no combinational path exists from cpu_* inputs to any output.

Reset
REQ-033 reset=0 at a rising edge forces:
  - trace_valid=0, trace_level=0, overflow=0, drop_cnt=0, halt=0, done=0;
  - trace_data=0;
  - both pointers=0;
  - FSM=RUN.
REQ-034 Reset applied mid-operation discards all FIFO contents with no pop side effects; FIFO storage need not be cleared.
REQ-035 While reset=0, pushes, detects and pops are all ignored.
REQ-036 The first push can occur in the first cycle with reset=1.

Verification
REQ-037 DEPTH=8, trace_ready=1; idle pulse with A=01, B=02, M=03, P=04 -> next cycle trace_valid=1 and trace_data=32'h01020304; one cycle later trace_valid=0.
REQ-038 trace_ready=0; 10 idle pulses -> trace_level=8, overflow=1, drop_cnt=2; then trace_ready=1 pops the first 8 entries in push order.
REQ-039 exec with op=11, M=0x1F, P=0x20, FIFO holding 3 entries -> halt=1 next cycle, FSM=DRAIN; later idle pulses add nothing; after 3 pops, done=1.
REQ-040 exec with op=11, P=0x00, M=0xFF, FIFO empty -> halt=1 and done=1 on the same edge; exec with op=11, P=0x21, M=0x1F -> no halt.
REQ-041 FIFO full with push and pop in one cycle -> level stays 8, drop_cnt unchanged; reset=0 for one cycle mid-stream -> all outputs return to the REQ-033 values.

Source files
------------

// File: rtl/tinycpu_trace.sv
// Trace FIFO that snapshots CPU registers at instruction boundaries
// and halts capture once a forever loop is detected.
module tinycpu_trace #(
  parameter int         DEPTH   = 8,
  parameter logic [1:0] LOOP_OP = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_idle,
  input  logic        cpu_exec,
  input  logic [1:0]  cpu_op,
  input  logic [7:0]  cpu_ra,
  input  logic [7:0]  cpu_rb,
  input  logic [7:0]  cpu_rm,
  input  logic [7:0]  cpu_rp,
  input  logic        trace_ready,
  output logic        trace_valid,
  output logic [31:0] trace_data,
  output logic [4:0]  trace_level,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic        halt,
  output logic        done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [4:0]      level;
  logic [4:0]      level_nxt;
  logic [7:0]      rp_m1;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            drop;
  logic            full;
  logic            detect;

  assign rp_m1    = cpu_rp - 8'd1;
  assign detect   = cpu_exec & (cpu_op == LOOP_OP) & (rp_m1 == cpu_rm);
  assign push_req = cpu_idle & ~halt;
  assign full     = (level == 5'(DEPTH));
  assign pop      = trace_valid & trace_ready;
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign level_nxt = level + {4'd0, push_ok} - {4'd0, pop};

  assign trace_valid = (level != 5'd0);
  assign trace_level = level;
  // Gating keeps the head at zero while empty, since storage is not reset.
  assign trace_data  = trace_valid ? mem[rptr] : 32'd0;

  always_ff @(posedge clk) begin
    if (reset && push_ok)
      mem[wptr] <= {cpu_ra, cpu_rb, cpu_rm, cpu_rp};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= 5'd0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (push_ok)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      level <= level_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hff)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (detect)
          state_nxt = (level_nxt == 5'd0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (level_nxt == 5'd0)
          state_nxt = DONE;
      end
      DONE: state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    halt = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN: begin
        halt = 1'b0;
        done = 1'b0;
      end
      DRAIN: begin
        halt = 1'b1;
        done = 1'b0;
      end
      DONE: begin
        halt = 1'b1;
        done = 1'b1;
      end
      default: begin
        halt = 1'b0;
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tinycpu_trace.sv
// Random and directed stimulus for tinycpu_trace against a queue-based
// reference model of the trace FIFO and halt/done flags.
module tb_tinycpu_trace;

  localparam int         DEPTH = 8;
  localparam logic [1:0] LOOP  = 2'b11;

  logic        clk;
  logic        reset;
  logic        cpu_idle;
  logic        cpu_exec;
  logic [1:0]  cpu_op;
  logic [7:0]  cpu_ra;
  logic [7:0]  cpu_rb;
  logic [7:0]  cpu_rm;
  logic [7:0]  cpu_rp;
  logic        trace_ready;
  logic        trace_valid;
  logic [31:0] trace_data;
  logic [4:0]  trace_level;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        halt;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  int          m_drop;
  bit          m_ov;
  bit          m_halt;
  bit          m_done;

  tinycpu_trace #(.DEPTH(DEPTH), .LOOP_OP(LOOP)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_idle(cpu_idle),
    .cpu_exec(cpu_exec),
    .cpu_op(cpu_op),
    .cpu_ra(cpu_ra),
    .cpu_rb(cpu_rb),
    .cpu_rm(cpu_rm),
    .cpu_rp(cpu_rp),
    .trace_ready(trace_ready),
    .trace_valid(trace_valid),
    .trace_data(trace_data),
    .trace_level(trace_level),
    .overflow(overflow),
    .drop_cnt(drop_cnt),
    .halt(halt),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0;
    m_ov   = 1'b0;
    m_halt = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic step(input logic i, input logic e, input logic [1:0] op,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] m, input logic [7:0] p,
                      input logic rd, input logic rs);
    int sz;
    bit pp;
    bit ph;
    bit dt;
    logic [7:0] pm1;
    cpu_idle    = i;
    cpu_exec    = e;
    cpu_op      = op;
    cpu_ra      = a;
    cpu_rb      = b;
    cpu_rm      = m;
    cpu_rp      = p;
    trace_ready = rd;
    reset       = rs;
    @(negedge clk);
    sz = q.size();
    chk("valid", 32'(trace_valid), 32'(sz > 0));
    chk("data", trace_data, (sz > 0) ? q[0] : 32'd0);
    chk("level", 32'(trace_level), 32'(sz));
    chk("ovf", 32'(overflow), 32'(m_ov));
    chk("drop", 32'(drop_cnt), 32'(m_drop));
    chk("halt", 32'(halt), 32'(m_halt));
    chk("done", 32'(done), 32'(m_done));
    if (!rs) begin
      model_reset();
    end else begin
      pm1 = p - 8'd1;
      pp  = (sz > 0) && rd;
      ph  = i && !m_halt;
      dt  = e && (op == LOOP) && (pm1 == m);
      if (pp)
        void'(q.pop_front());
      if (ph) begin
        if (sz < DEPTH || pp) begin
          q.push_back({a, b, m, p});
        end else begin
          m_ov = 1'b1;
          if (m_drop < 255)
            m_drop++;
        end
      end
      if (!m_halt) begin
        if (dt) begin
          m_halt = 1'b1;
          m_done = (q.size() == 0);
        end
      end else if (!m_done && q.size() == 0) begin
        m_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_push(input logic [7:0] tag, input logic rd);
    step(1'b1, 1'b0, 2'b00, tag, tag + 8'd1, tag + 8'd2, tag + 8'd3,
         rd, 1'b1);
  endtask

  task automatic nop(input logic rd);
    step(1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, rd, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic rand_phase(input int n, input int rdy_pct,
                            input int det_pct);
    logic [7:0] p;
    logic [7:0] m;
    for (int k = 0; k < n; k++) begin
      p = 8'($urandom);
      m = ($urandom_range(0, 99) < det_pct) ? p - 8'd1 : 8'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           2'($urandom), 8'($urandom), 8'($urandom), m, p,
           1'($urandom_range(0, 99) < rdy_pct),
           1'($urandom_range(0, 299) != 0));
    end
  endtask

  initial begin
    reset       = 1'b0;
    cpu_idle    = 1'b0;
    cpu_exec    = 1'b0;
    cpu_op      = 2'b00;
    cpu_ra      = 8'd0;
    cpu_rb      = 8'd0;
    cpu_rm      = 8'd0;
    cpu_rp      = 8'd0;
    trace_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_lvl", 32'(trace_level), 32'd0);

    // single snapshot with immediate consumer
    step(1'b1, 1'b0, 2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b1);
    chk("p37_v", 32'(trace_valid), 32'd1);
    chk("p37_d", trace_data, 32'h01020304);
    nop(1'b1);
    chk("p37_v0", 32'(trace_valid), 32'd0);

    // overflow with stalled consumer, then in-order drain
    for (int k = 0; k < 10; k++)
      idle_push(8'(k * 16), 1'b0);
    chk("p38_lvl", 32'(trace_level), 32'd8);
    chk("p38_ovf", 32'(overflow), 32'd1);
    chk("p38_drp", 32'(drop_cnt), 32'd2);
    chk("p38_hd", trace_data, 32'h00010203);
    // full with push and pop together
    idle_push(8'hA0, 1'b1);
    chk("p41_lvl", 32'(trace_level), 32'd8);
    chk("p41_drp", 32'(drop_cnt), 32'd2);
    chk("p41_hd", trace_data, 32'h10111213);
    for (int k = 0; k < 9; k++)
      nop(1'b1);
    chk("p38_emp", 32'(trace_level), 32'd0);

    // mid-stream reset clears everything
    idle_push(8'h55, 1'b0);
    do_reset();
    chk("p41_rv", 32'(trace_valid), 32'd0);
    chk("p41_rd", trace_data, 32'd0);
    chk("p41_ro", 32'(overflow), 32'd0);

    // loop detect with 3 entries queued
    for (int k = 0; k < 3; k++)
      idle_push(8'(8'h30 + k), 1'b0);
    step(1'b0, 1'b1, 2'b11, 8'd0, 8'd0, 8'h1F, 8'h20, 1'b0, 1'b1);
    chk("p39_h", 32'(halt), 32'd1);
    chk("p39_d", 32'(done), 32'd0);
    idle_push(8'h77, 1'b0);
    chk("p39_lvl", 32'(trace_level), 32'd3);
    for (int k = 0; k < 3; k++)
      nop(1'b1);
    chk("p39_dn", 32'(done), 32'd1);

    // detect into empty FIFO with wrap of P
    do_reset();
    step(1'b0, 1'b1, 2'b11, 8'd0, 8'd0, 8'hFF, 8'h00, 1'b1, 1'b1);
    chk("p40_h", 32'(halt), 32'd1);
    chk("p40_d", 32'(done), 32'd1);
    do_reset();
    step(1'b0, 1'b1, 2'b11, 8'd0, 8'd0, 8'h1F, 8'h21, 1'b1, 1'b1);
    chk("p40_nh", 32'(halt), 32'd0);

    // drop counter saturation
    do_reset();
    for (int k = 0; k < 270; k++)
      idle_push(8'(k), 1'b0);
    chk("sat", 32'(drop_cnt), 32'd255);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      rand_phase(400, 20 + r * 10, (r % 2 == 0) ? 1 : 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
